// File: rtl/dac_spi_receiver.sv
// Receiver/model for an MCP4922-style dual 12-bit SPI DAC: decodes 16-bit command
// words into per-channel input registers and transfers them to the outputs on a latch fall.
`timescale 1ns/1ps
module dac_spi_receiver #(
    parameter int WORD_BITS   = 16,
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dac_sclk,
    input  logic                 dac_mosi,
    input  logic                 dac_csn,
    input  logic                 dac_latchn,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_valid,
    output logic                 frame_err,
    output logic [DATA_BITS-1:0] dac_a,
    output logic [DATA_BITS-1:0] dac_b,
    output logic                 dac_a_on,
    output logic                 dac_b_on,
    output logic                 dac_a_gain1x,
    output logic                 dac_b_gain1x,
    output logic                 latch_pulse
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [5:0] CNT_MAX  = 6'd63;
    localparam logic [5:0] CNT_WORD = 6'(WORD_BITS);
    localparam int         REG_BITS = DATA_BITS + 2;   // {GA, SHDN, code}

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync, latchn_sync;
    logic                   sclk_hist, csn_hist, latchn_hist;

    // Idle-high lines reset to 1 so releasing reset never fakes a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync   <= '0;
            mosi_sync   <= '0;
            csn_sync    <= '1;
            latchn_sync <= '1;
            sclk_hist   <= 1'b0;
            csn_hist    <= 1'b1;
            latchn_hist <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values, so the chain shifts by exactly one stage per clock.
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], dac_sclk};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], dac_mosi};
            csn_sync    <= {csn_sync[SYNC_STAGES-2:0], dac_csn};
            latchn_sync <= {latchn_sync[SYNC_STAGES-2:0], dac_latchn};
            sclk_hist   <= sclk_sync[SYNC_STAGES-1];
            csn_hist    <= csn_sync[SYNC_STAGES-1];
            latchn_hist <= latchn_sync[SYNC_STAGES-1];
        end
    end

    logic mosi_s, sclk_rise, csn_fall, csn_rise, latch_fall;

    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise  =  sclk_sync[SYNC_STAGES-1]   & ~sclk_hist;
    assign csn_fall   = ~csn_sync[SYNC_STAGES-1]    &  csn_hist;
    assign csn_rise   =  csn_sync[SYNC_STAGES-1]    & ~csn_hist;
    assign latch_fall = ~latchn_sync[SYNC_STAGES-1] &  latchn_hist;

    logic [1:0]           state;
    logic [5:0]           bit_cnt;
    logic [WORD_BITS-1:0] shift_reg;
    logic [REG_BITS-1:0]  in_a, in_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            in_a         <= '0;
            in_b         <= '0;
            word         <= '0;
            word_valid   <= 1'b0;
            frame_err    <= 1'b0;
            dac_a        <= '0;
            dac_b        <= '0;
            dac_a_on     <= 1'b0;
            dac_b_on     <= 1'b0;
            dac_a_gain1x <= 1'b0;
            dac_b_gain1x <= 1'b0;
            latch_pulse  <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            frame_err   <= 1'b0;
            latch_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_s};
                        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
                    end
                    if (csn_rise) state <= CHECK;
                end
                CHECK: begin
                    if (bit_cnt == CNT_WORD) begin
                        word       <= shift_reg;
                        word_valid <= 1'b1;
                        if (shift_reg[WORD_BITS-1])
                            in_b <= {shift_reg[WORD_BITS-3], shift_reg[WORD_BITS-4],
                                     shift_reg[DATA_BITS-1:0]};
                        else
                            in_a <= {shift_reg[WORD_BITS-3], shift_reg[WORD_BITS-4],
                                     shift_reg[DATA_BITS-1:0]};
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Reads in_a/in_b before this cycle's commit lands, so a coinciding
            // commit only becomes visible at the following latch.
            if (latch_fall) begin
                {dac_a_gain1x, dac_a_on, dac_a} <= in_a;
                {dac_b_gain1x, dac_b_on, dac_b} <= in_b;
                latch_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Self-checking bench for dac_spi_receiver: directed scenarios plus randomized frames
// checked against a word-level DAC model.
`timescale 1ns/1ps
module tb_dac_spi_receiver;
    localparam int WB = 16;
    localparam int DB = 12;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dac_sclk = 1'b0, dac_mosi = 1'b0, dac_csn = 1'b1, dac_latchn = 1'b1;
    logic [WB-1:0] word;
    logic          word_valid, frame_err, latch_pulse;
    logic [DB-1:0] dac_a, dac_b;
    logic          dac_a_on, dac_b_on, dac_a_gain1x, dac_b_gain1x;

    dac_spi_receiver #(.WORD_BITS(WB), .DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset),
        .dac_sclk(dac_sclk), .dac_mosi(dac_mosi), .dac_csn(dac_csn), .dac_latchn(dac_latchn),
        .word(word), .word_valid(word_valid), .frame_err(frame_err),
        .dac_a(dac_a), .dac_b(dac_b), .dac_a_on(dac_a_on), .dac_b_on(dac_b_on),
        .dac_a_gain1x(dac_a_gain1x), .dac_b_gain1x(dac_b_gain1x), .latch_pulse(latch_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    int wv_cnt = 0, err_cnt = 0, lp_cnt = 0;
    int exp_wv = 0, exp_err = 0, exp_lp = 0;

    // Model: last good word, per-channel {GA, SHDN, code} input and output registers.
    logic [15:0] m_word = '0;
    logic [13:0] m_in[2];
    logic [13:0] m_out[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (word_valid)  wv_cnt++;
            if (frame_err)   err_cnt++;
            if (latch_pulse) lp_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_word = '0;
        for (int c = 0; c < 2; c++) begin
            m_in[c]  = '0;
            m_out[c] = '0;
        end
    endtask

    task automatic model_latch();
        for (int c = 0; c < 2; c++) m_out[c] = m_in[c];
        exp_lp++;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".word"},     32'(word),         32'(m_word));
        check({tag, ".dac_a"},    32'(dac_a),        32'(m_out[0][11:0]));
        check({tag, ".a_on"},     32'(dac_a_on),     32'(m_out[0][12]));
        check({tag, ".a_gain"},   32'(dac_a_gain1x), 32'(m_out[0][13]));
        check({tag, ".dac_b"},    32'(dac_b),        32'(m_out[1][11:0]));
        check({tag, ".b_on"},     32'(dac_b_on),     32'(m_out[1][12]));
        check({tag, ".b_gain"},   32'(dac_b_gain1x), 32'(m_out[1][13]));
        check({tag, ".n_valid"},  32'(wv_cnt),       32'(exp_wv));
        check({tag, ".n_err"},    32'(err_cnt),      32'(exp_err));
        check({tag, ".n_latch"},  32'(lp_cnt),       32'(exp_lp));
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            dac_mosi = bits[i];
            tick(3);
            dac_sclk = 1'b1;
            tick(3);
            dac_sclk = 1'b0;
        end
    endtask

    // Sends one frame; optionally measures word_valid latency or lands a latch fall on CHECK.
    task automatic send_frame(input logic [31:0] bits, input int nbits,
                              input bit latch_on_check, input bit measure);
        int lat;
        dac_csn = 1'b0;
        tick(4);
        shift_bits(bits, nbits);
        tick(3);
        dac_csn = 1'b1;
        if (measure) begin
            lat = -1;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (word_valid) begin
                    lat = k;
                    break;
                end
            end
            check("latency", 32'(lat), 32'(SS + 2));
        end
        if (latch_on_check) begin
            tick(1);
            dac_latchn = 1'b0;
            tick(6);
            dac_latchn = 1'b1;
            model_latch();
        end
        tick(10);
        if (nbits == WB) begin
            m_word = bits[15:0];
            m_in[int'(bits[15])] = {bits[13], bits[12], bits[11:0]};
            exp_wv++;
        end else begin
            exp_err++;
        end
    endtask

    task automatic pulse_latch();
        dac_latchn = 1'b0;
        tick(8);
        dac_latchn = 1'b1;
        tick(6);
        model_latch();
    endtask

    initial begin
        logic [31:0] bits;
        int          nb;
        model_reset();

        tick(3);
        check_outputs("reset");
        check("reset.wv", 32'(word_valid), 32'd0);
        check("reset.lp", 32'(latch_pulse), 32'd0);
        reset = 1'b1;
        tick(4);

        send_frame(32'h3ABC, 16, 1'b0, 1'b1);
        check("t1.word", 32'(word), 32'h3ABC);
        pulse_latch();
        check("t1.dac_a", 32'(dac_a), 32'hABC);
        check_outputs("t1");

        send_frame(32'hB123, 16, 1'b0, 1'b0);
        send_frame(32'h1FFF, 16, 1'b0, 1'b0);
        pulse_latch();
        check("t2.dac_b", 32'(dac_b), 32'h123);
        check_outputs("t2");

        send_frame(32'h5A5A, 15, 1'b0, 1'b0);
        send_frame(32'h1A5A5, 17, 1'b0, 1'b0);
        check_outputs("t3");

        send_frame(32'h3555, 16, 1'b1, 1'b0);
        check("t4.dac_a_old", 32'(dac_a), 32'hFFF);
        check_outputs("t4a");
        pulse_latch();
        check_outputs("t4b");

        // Reset in the middle of a frame.
        dac_csn = 1'b0;
        tick(4);
        shift_bits(32'h3A, 8);
        reset = 1'b0;
        dac_csn = 1'b1;
        tick(4);
        model_reset();
        check_outputs("t5.in_reset");
        reset = 1'b1;
        tick(20);
        check_outputs("t5.after");
        send_frame(32'hB0F0, 16, 1'b0, 1'b0);
        pulse_latch();
        check_outputs("t5.final");

        for (int i = 0; i < 20; i++) begin
            dac_sclk = 1'b1;
            tick(3);
            dac_sclk = 1'b0;
            tick(3);
        end
        tick(10);
        check_outputs("t6");

        for (int it = 0; it < 30; it++) begin
            bits = $urandom;
            case ($urandom_range(0, 5))
                0:       nb = 15;
                1:       nb = 17;
                default: nb = 16;
            endcase
            bits = bits & ((32'd1 << nb) - 32'd1);
            send_frame(bits, nb, 1'($urandom_range(0, 4) == 0), 1'b0);
            if ($urandom_range(0, 1) == 1) pulse_latch();
            check_outputs("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
